// File: rtl/step_scheduler_pkg.sv
// step_scheduler_pkg
// Shared encodings for the step scheduler: the 2-bit FSM state codes, the
// request-source codes, and a helper that decides whether the next step in
// the current direction would leave the soft travel window.
package step_scheduler_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETUP   = 2'd1;
   localparam logic [1:0] ST_STEP_HI = 2'd2;
   localparam logic [1:0] ST_STEP_LO = 2'd3;

   localparam logic SRC_TRK = 1'b0;
   localparam logic SRC_OVR = 1'b1;

   // True when the carriage already sits on the limit it is heading towards.
   function automatic logic at_limit(input logic [15:0] pos,
                                     input logic        dir_right,
                                     input logic [15:0] pos_min,
                                     input logic [15:0] pos_max);
      at_limit = (dir_right && (pos == pos_max)) || (!dir_right && (pos == pos_min));
   endfunction

endpackage

// File: rtl/step_scheduler_timer.sv
// step_timer
// 16-bit loadable down-counter shared by every timed FSM phase. A phase that
// must last N cycles loads N-1; expire is high while the count is zero, which
// marks the last cycle of the phase.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   load, load_value   reload the counter with load_value on the next edge
//   count              current counter value
//   expire             count has reached zero
module step_timer (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   output logic [15:0] count,
   output logic        expire
);

   // Count down towards zero and park there until the next load.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= 16'd0;
      end else if (load) begin
         count <= load_value;
      end else if (count != 16'd0) begin
         count <= count - 16'd1;
      end
   end

   assign expire = (count == 16'd0);

endmodule

// File: rtl/step_scheduler.sv
// step_scheduler
// Arbitrates between a manual override and an auto-tracker, then produces
// step/dir pulses for a stepper driver while tracking a signed position
// inside soft travel limits. The override may preempt a running tracker job
// at the end of a step's low phase.
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   ovr_req/ovr_dir/ovr_val       override request, direction (1 = +), steps
//   trk_req/trk_dir/trk_val       tracker request, direction (1 = +), steps
//   ovr_ack, trk_ack              one-cycle pulse when a request is latched
//   step, dir                     motor driver outputs
//   busy                          high whenever the FSM is not idle
//   done, done_src                completion pulse and its source (1 = override)
//   trk_abort, limit_hit          tracker preempted / soft limit stopped a job
//   position                      signed step position
module step_scheduler
   import step_scheduler_pkg::*;
#(
   parameter logic        [15:0] STEP_PERIOD = 16'd50000,
   parameter logic        [15:0] PULSE_WIDTH = 16'd100,
   parameter logic        [7:0]  DIR_SETUP   = 8'd4,
   parameter logic signed [15:0] POS_MIN     = -16'sd2000,
   parameter logic signed [15:0] POS_MAX     = 16'sd2000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ovr_req,
   input  logic        ovr_dir,
   input  logic [7:0]  ovr_val,
   input  logic        trk_req,
   input  logic        trk_dir,
   input  logic [7:0]  trk_val,
   output logic        ovr_ack,
   output logic        trk_ack,
   output logic        step,
   output logic        dir,
   output logic        busy,
   output logic        done,
   output logic        done_src,
   output logic        trk_abort,
   output logic        limit_hit,
   output logic [15:0] position
);

   logic [1:0]  state;
   logic [7:0]  remaining;
   logic        source;

   logic        timer_load;
   logic [15:0] timer_value;
   logic [15:0] timer_count;
   logic        timer_expire;

   logic        take_ovr;
   logic        take_trk;
   logic        take_any;
   logic        zero_job;
   logic        preempt;
   logic        start_pulse;
   logic        end_pulse;
   logic        finish;
   logic        stop_limit;
   logic        limit_now;
   logic        new_dir;
   logic [7:0]  new_val;

   step_timer u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .count      (timer_count),
      .expire     (timer_expire)
   );

   assign limit_now = at_limit(position, dir, POS_MIN, POS_MAX);

   // Decide what happens at the coming edge. Every transition is reduced to a
   // handful of event flags so the register block below stays a flat list of
   // consequences. Preemption is checked before normal completion so a
   // waiting override always wins at a step boundary.
   always_comb begin
      take_ovr    = 1'b0;
      take_trk    = 1'b0;
      preempt     = 1'b0;
      start_pulse = 1'b0;
      end_pulse   = 1'b0;
      finish      = 1'b0;
      stop_limit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ovr_req) begin
               take_ovr = 1'b1;
            end else if (trk_req) begin
               take_trk = 1'b1;
            end
         end
         ST_SETUP: begin
            if (timer_expire) begin
               if (limit_now) stop_limit = 1'b1;
               else           start_pulse = 1'b1;
            end
         end
         ST_STEP_HI: begin
            if (timer_expire) end_pulse = 1'b1;
         end
         ST_STEP_LO: begin
            if (timer_expire) begin
               if ((source == SRC_TRK) && ovr_req) begin
                  preempt  = 1'b1;
                  take_ovr = 1'b1;
               end else if (remaining == 8'd0) begin
                  finish = 1'b1;
               end else if (limit_now) begin
                  stop_limit = 1'b1;
               end else begin
                  start_pulse = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Request latching helpers and the timer reload value for the next phase.
   always_comb begin
      take_any = take_ovr | take_trk;
      new_dir  = take_ovr ? ovr_dir : trk_dir;
      new_val  = take_ovr ? ovr_val : trk_val;
      zero_job = take_any && (new_val == 8'd0);
      timer_load = (take_any && !zero_job) || start_pulse || end_pulse;
      if (start_pulse) begin
         timer_value = PULSE_WIDTH - 16'd1;
      end else if (end_pulse) begin
         timer_value = STEP_PERIOD - PULSE_WIDTH - 16'd1;
      end else begin
         timer_value = {8'd0, DIR_SETUP - 8'd1};
      end
   end

   // Registered state and outputs. Pulse outputs are rewritten every cycle so
   // they last exactly one clock. A zero-length job is acked and completed in
   // the same cycle without touching dir, step or position.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         remaining <= 8'd0;
         source    <= SRC_TRK;
         step      <= 1'b0;
         dir       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_src  <= 1'b0;
         ovr_ack   <= 1'b0;
         trk_ack   <= 1'b0;
         trk_abort <= 1'b0;
         limit_hit <= 1'b0;
         position  <= 16'd0;
      end else begin
         ovr_ack   <= take_ovr;
         trk_ack   <= take_trk;
         trk_abort <= preempt;
         limit_hit <= stop_limit;
         done      <= finish | stop_limit | zero_job;

         if (take_any) begin
            source <= take_ovr ? SRC_OVR : SRC_TRK;
         end

         if (zero_job) begin
            done_src  <= take_ovr;
            remaining <= 8'd0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
         end else if (take_any) begin
            dir       <= new_dir;
            remaining <= new_val;
            state     <= ST_SETUP;
            busy      <= 1'b1;
         end else if (start_pulse) begin
            step  <= 1'b1;
            state <= ST_STEP_HI;
         end else if (end_pulse) begin
            step      <= 1'b0;
            state     <= ST_STEP_LO;
            remaining <= remaining - 8'd1;
            position  <= dir ? (position + 16'd1) : (position - 16'd1);
         end else if (finish || stop_limit) begin
            done_src <= source;
            state    <= ST_IDLE;
            busy     <= 1'b0;
         end
      end
   end

endmodule
